// File: rtl/div_dispatch_pkg.sv
// Shared definitions for the divider dispatch block: default sizing and FSM state encoding.
package div_dispatch_pkg;

    // Default sizing; DATA_WIDTH matches the divider datapath width
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_TAG_WIDTH   = 2;
    localparam int DEF_DEPTH       = 2;
    localparam int DEF_DIV_LATENCY = 1;

    // Dispatch FSM states, encoded to match the divider team's state numbering
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_RESP = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_op_fifo.sv
// Small request FIFO holding {tag, op2, op1} entries in registered storage.
module div_op_fifo
    import div_dispatch_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATA_WIDTH + DEF_TAG_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never accepts, even if the head leaves in the same cycle
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; only slots between the pointers are ever read
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/div_dispatch.sv
// Feeds queued operand pairs to the multi-cycle divider one at a time and returns tagged quotients.
module div_dispatch
    import div_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_op1,
    input  logic [DATA_WIDTH-1:0] in_op2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  div_enable,
    output logic [DATA_WIDTH-1:0] div_op1,
    output logic [DATA_WIDTH-1:0] div_op2,
    input  logic [DATA_WIDTH-1:0] div_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_div_by_zero,
    output logic                  busy
);

    localparam int ENTRY_W = TAG_WIDTH + 2 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD    = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_RESULT = {DATA_WIDTH{1'b1}};

    div_state_t state;
    div_state_t next_state;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [DATA_WIDTH-1:0] head_op1;
    logic [DATA_WIDTH-1:0] head_op2;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [CNT_W-1:0]      cnt;

    // Reset gates ready combinationally so nothing is accepted while reset is held
    assign in_ready  = !fifo_full && !reset;
    assign fifo_push = in_valid && in_ready;

    assign head_op1 = fifo_head[DATA_WIDTH-1:0];
    assign head_op2 = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_tag = fifo_head[ENTRY_W-1:2*DATA_WIDTH];

    assign div_op1  = op1_q;
    assign div_op2  = op2_q;
    assign out_tag  = tag_q;
    assign busy     = (state != DIV_IDLE) || !fifo_empty;

    div_op_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_tag, in_op2, in_op1}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= DIV_IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake outputs; zero divisors skip straight to the response
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        div_enable = 1'b0;
        out_valid  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = (head_op2 != '0) ? DIV_BUSY : DIV_RESP;
                end
            end
            DIV_BUSY: begin
                div_enable = 1'b1;
                if (cnt == CNT_ONE) next_state = DIV_RESP;
            end
            DIV_RESP: begin
                out_valid = 1'b1;
                if (out_ready) next_state = DIV_IDLE;
            end
            default: next_state = DIV_IDLE;
        endcase
    end

    // Operand, latency counter and result registers; results hold until the consumer takes them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op1_q           <= '0;
            op2_q           <= '0;
            tag_q           <= '0;
            cnt             <= '0;
            out_result      <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (fifo_pop) begin
                        op1_q <= head_op1;
                        op2_q <= head_op2;
                        tag_q <= head_tag;
                        if (head_op2 == '0) begin
                            out_result      <= ZERO_RESULT;
                            out_div_by_zero <= 1'b1;
                        end else begin
                            cnt <= CNT_LOAD;
                        end
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_result      <= div_result;
                        out_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_dispatch.sv
// Directed self-checking bench for div_dispatch with a combinational stub divider.
module tb_div_dispatch;

    localparam int DW    = 8;
    localparam int TW    = 2;
    localparam int DEPTH = 2;
    localparam int LAT   = 1;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_op1;
    logic [DW-1:0] in_op2;
    logic [TW-1:0] in_tag;
    logic          div_enable;
    logic [DW-1:0] div_op1;
    logic [DW-1:0] div_op2;
    logic [DW-1:0] div_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          out_div_by_zero;
    logic          busy;

    int assertCount = 0;
    int failCount   = 0;

    // Completed transfers as {div_by_zero, tag, result}
    logic [10:0] got[$];

    div_dispatch #(
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .DEPTH       (DEPTH),
        .DIV_LATENCY (LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op1          (in_op1),
        .in_op2          (in_op2),
        .in_tag          (in_tag),
        .div_enable      (div_enable),
        .div_op1         (div_op1),
        .div_op2         (div_op2),
        .div_result      (div_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_tag         (out_tag),
        .out_div_by_zero (out_div_by_zero),
        .busy            (busy)
    );

    // Stub divider: plain unsigned quotient of whatever the dispatcher presents
    assign div_result = (div_op2 != '0) ? div_op1 / div_op2 : '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record each accepted result in the middle of the cycle, where the handshake is settled
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready)
            got.push_back({out_div_by_zero, out_tag, out_result});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] pack(input logic dbz, input logic [1:0] tag, input logic [7:0] res);
        return {dbz, tag, res};
    endfunction

    // Present one request and hold it until the edge that accepts it
    task automatic applyStimulus(input logic [7:0] op1, input logic [7:0] op2, input logic [1:0] tag);
        int n;
        in_valid = 1'b1;
        in_op1   = op1;
        in_op2   = op2;
        in_tag   = tag;
        n = 0;
        while (!in_ready && n < 100) begin
            stepCycle();
            n++;
        end
        if (!in_ready) checkOutput("push_timeout", 32'(in_ready), 1);
        stepCycle();
        in_valid = 1'b0;
    endtask

    // Called just after the handshake edge with out_ready high; checks latency, enable window and result
    task automatic waitResult(input logic [7:0] op1e, input logic [7:0] op2e, input logic [7:0] rese,
                              input logic [1:0] tage, input logic dbze, input int enExp, input int latExp);
        int k;
        int en;
        k  = 0;
        en = 0;
        while (!out_valid && k < 40) begin
            if (div_enable) begin
                en++;
                checkOutput("div_op1", 32'(div_op1), 32'(op1e));
                checkOutput("div_op2", 32'(div_op2), 32'(op2e));
            end
            stepCycle();
            k++;
        end
        checkOutput("latency", k, latExp);
        checkOutput("enable_cycles", en, enExp);
        checkOutput("out_result", 32'(out_result), 32'(rese));
        checkOutput("out_tag", 32'(out_tag), 32'(tage));
        checkOutput("out_div_by_zero", 32'(out_div_by_zero), 32'(dbze));
        checkOutput("enable_in_resp", 32'(div_enable), 0);
        stepCycle();
        checkOutput("valid_drop", 32'(out_valid), 0);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput(name, 32'(busy), 0);
    endtask

    task automatic checkEntry(input string name, input int idx, input logic [10:0] expv);
        logic [31:0] act;
        act = (idx < got.size()) ? 32'(got[idx]) : 32'hFFFF_FFFF;
        checkOutput(name, act, 32'(expv));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 0);
        checkOutput({name, "_div_enable"}, 32'(div_enable), 0);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({name, "_busy"}, 32'(busy), 0);
        checkOutput({name, "_ops"}, {16'd0, div_op1, div_op2}, 0);
        checkOutput({name, "_result"}, {22'd0, out_div_by_zero, out_tag, out_result}, 0);
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        $display("[TB] reset checks");
        stepCycle();
        checkResetOutputs("reset_c1");
        stepCycle();
        checkResetOutputs("reset_c2");
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 1);
        checkOutput("post_reset_busy", 32'(busy), 0);

        $display("[TB] normal division 15/4");
        out_ready = 1'b1;
        stepCycle();
        applyStimulus(8'd15, 8'd4, 2'd1);
        checkOutput("t2_enable_idle", 32'(div_enable), 0);
        waitResult(8'd15, 8'd4, 8'd3, 2'd1, 1'b0, LAT, 1 + LAT);

        $display("[TB] divide by zero 9/0");
        applyStimulus(8'd9, 8'd0, 2'd2);
        waitResult(8'd9, 8'd0, 8'hFF, 2'd2, 1'b1, 0, 1);

        $display("[TB] backpressure with three requests");
        out_ready = 1'b0;
        base = got.size();
        applyStimulus(8'd10, 8'd2, 2'd0);
        applyStimulus(8'd12, 8'd3, 2'd1);
        applyStimulus(8'd7, 8'd7, 2'd3);
        checkOutput("t4_full_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("t4_hold_valid", 32'(out_valid), 1);
            checkOutput("t4_hold_result", 32'(out_result), 5);
            checkOutput("t4_hold_tag", 32'(out_tag), 0);
        end
        out_ready = 1'b1;
        waitIdle("t4_drain_timeout");
        checkOutput("t4_count", got.size() - base, 3);
        checkEntry("t4_first", base, pack(1'b0, 2'd0, 8'd5));
        checkEntry("t4_second", base + 1, pack(1'b0, 2'd1, 8'd4));
        checkEntry("t4_third", base + 2, pack(1'b0, 2'd3, 8'd1));

        $display("[TB] full FIFO refuses push");
        out_ready = 1'b0;
        base = got.size();
        applyStimulus(8'd20, 8'd5, 2'd0);
        applyStimulus(8'd30, 8'd3, 2'd1);
        applyStimulus(8'd40, 8'd0, 2'd2);
        in_valid = 1'b1;
        in_op1   = 8'd50;
        in_op2   = 8'd10;
        in_tag   = 2'd3;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("t5_in_ready_full", 32'(in_ready), 0);
            checkOutput("t5_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        applyStimulus(8'd50, 8'd10, 2'd3);
        waitIdle("t5_drain_timeout");
        checkOutput("t5_count", got.size() - base, 4);
        checkEntry("t5_first", base, pack(1'b0, 2'd0, 8'd4));
        checkEntry("t5_second", base + 1, pack(1'b0, 2'd1, 8'd10));
        checkEntry("t5_third", base + 2, pack(1'b1, 2'd2, 8'hFF));
        checkEntry("t5_fourth", base + 3, pack(1'b0, 2'd3, 8'd5));

        $display("[TB] reset during division");
        base = got.size();
        applyStimulus(8'd200, 8'd7, 2'd1);
        stepCycle();
        checkOutput("t6_busy_enable", 32'(div_enable), 1);
        reset = 1'b1;
        #1;
        checkResetOutputs("t6_async");
        stepCycle();
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("t6_no_valid", 32'(out_valid), 0);
        end
        checkOutput("t6_no_output", got.size() - base, 0);
        checkOutput("t6_idle_busy", 32'(busy), 0);
        applyStimulus(8'd8, 8'd2, 2'd2);
        waitResult(8'd8, 8'd2, 8'd4, 2'd2, 1'b0, LAT, 1 + LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
